// File: rtl/fpmult_host.sv
// rtl/fpmult_host.sv - initiator FSM driving start/operand/done protocol of the serial FP multiplier
// Optional WAIT watchdog compiled in with FPMULT_HOST_TIMEOUT_EN.
module fpmult_host #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        busy,
    output logic        resValid,
    output logic [31:0] result,
    output logic        timeout,
    output logic        startFP,
    output logic [31:0] inBus,
    input  logic [31:0] resBus,
    input  logic        doneFP
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND_A,
        SEND_B,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("fpmult_host: TIMEOUT_CYCLES must be within 2..65535");
    end

`ifdef FPMULT_HOST_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt;
`else
    assign timeout = 1'b0;
`endif

    // Outputs are loaded with the value for the state being entered, so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            resValid <= 1'b0;
            result   <= '0;
            startFP  <= 1'b0;
            inBus    <= '0;
            a_q      <= '0;
            b_q      <= '0;
`ifdef FPMULT_HOST_TIMEOUT_EN
            timeout  <= 1'b0;
            wd_cnt   <= '0;
`endif
        end else begin
            startFP  <= 1'b0;
            resValid <= 1'b0;
`ifdef FPMULT_HOST_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        a_q     <= opA;
                        b_q     <= opB;
                        startFP <= 1'b1;
                        busy    <= 1'b1;
                        inBus   <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    inBus <= a_q;
                    state <= SEND_A;
                end
                SEND_A: begin
                    inBus <= b_q;
                    state <= SEND_B;
                end
                SEND_B: begin
                    inBus <= '0;
                    state <= WAIT;
`ifdef FPMULT_HOST_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    // doneFP is checked first so it wins a tie with the terminal count.
                    if (doneFP) begin
                        result   <= resBus;
                        resValid <= 1'b1;
                        state    <= DONE;
                    end
`ifdef FPMULT_HOST_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    inBus <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpmult_host.sv
// tb/tb_fpmult_host.sv - directed/randomized self-checking bench for fpmult_host
module tb_fpmult_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic [31:0] resBus = '0;
    logic        doneFP = 1'b0;
    logic        busy;
    logic        resValid;
    logic [31:0] result;
    logic        timeout;
    logic        startFP;
    logic [31:0] inBus;

    int          passed = 0;
    int          fails = 0;
    int          total = 0;
    logic [31:0] exp_result = '0;

    fpmult_host #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .opA(opA),
        .opB(opB),
        .busy(busy),
        .resValid(resValid),
        .result(result),
        .timeout(timeout),
        .startFP(startFP),
        .inBus(inBus),
        .resBus(resBus),
        .doneFP(doneFP)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic sfp, input logic [31:0] bus,
                             input logic bsy, input logic rv);
        check({tag, ".startFP"}, {31'd0, startFP}, {31'd0, sfp});
        check({tag, ".inBus"}, inBus, bus);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
        check({tag, ".resValid"}, {31'd0, resValid}, {31'd0, rv});
        check({tag, ".timeout"}, {31'd0, timeout}, 32'd0);
        check({tag, ".result"}, result, exp_result);
    endtask

    // Called at a negedge while the host is idle; returns at the negedge after busy drops.
    // The responder raises doneFP after d low WAIT cycles; stale holds doneFP high before WAIT.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                           input int d, input bit hold, input bit stale);
        logic [31:0] exp_bus[$];
        exp_bus = {32'h0, a, b};
        req = 1'b1;
        opA = a;
        opB = b;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_out("seq", (i == 0), exp_bus[i], 1'b1, 1'b0);
            if (!hold) req = 1'b0;
            opA = $urandom;
            opB = $urandom;
            doneFP = stale;
            resBus = $urandom;
            @(negedge clk);
        end
        for (int i = 0; i <= d; i++) begin
            check_out("wait", 1'b0, 32'h0, 1'b1, 1'b0);
            doneFP = (i == d);
            resBus = (i == d) ? p : $urandom;
            @(negedge clk);
        end
        exp_result = p;
        check_out("done", 1'b0, 32'h0, 1'b1, 1'b1);
        doneFP = 1'b0;
        resBus = $urandom;
        @(negedge clk);
        check_out("idle", 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset values, then a quiet idle period.
        @(negedge clk);
        check_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_out("quiet", 1'b0, 32'h0, 1'b0, 1'b0);
        end

        run_txn(32'h412B3333, 32'h40200000, 32'h41D60000, 5, 1'b0, 1'b0);

        for (int n = 0; n < 4; n++)
            run_txn($urandom, $urandom, $urandom, int'($urandom_range(0, 10)), 1'b0, 1'b0);
        run_txn($urandom, $urandom, $urandom, 0, 1'b0, 1'b0);

        // Back-to-back with req held high: next START one cycle after the idle sample.
        for (int n = 0; n < 3; n++)
            run_txn($urandom, $urandom, $urandom, 7, 1'b1, 1'b0);
        req = 1'b0;

        run_txn($urandom, $urandom, $urandom, 3, 1'b0, 1'b1);

        // Reset two cycles into WAIT.
        req = 1'b1;
        opA = $urandom;
        opB = $urandom;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_result = '0;
        check_out("rst_mid", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        doneFP = 1'b1;
        resBus = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out("post_rst", 1'b0, 32'h0, 1'b0, 1'b0);
        end
        doneFP = 1'b0;

        run_txn($urandom, $urandom, 32'hC0FFEE01, 2, 1'b0, 1'b0);

        req = 1'b1;
        opA = $urandom;
        opB = $urandom;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
`ifdef FPMULT_HOST_TIMEOUT_EN
        for (int j = 0; j < 8; j++) begin
            check("wd_busy", {31'd0, busy}, 32'd1);
            check("wd_quiet", {31'd0, timeout}, 32'd0);
            @(negedge clk);
        end
        check("wd_timeout", {31'd0, timeout}, 32'd1);
        check("wd_busy_drop", {31'd0, busy}, 32'd0);
        check("wd_resValid", {31'd0, resValid}, 32'd0);
        check("wd_result", result, exp_result);
        @(negedge clk);
        check("wd_timeout_end", {31'd0, timeout}, 32'd0);
`else
        for (int j = 0; j < 1000; j++) begin
            check("nowd_busy", {31'd0, busy}, 32'd1);
            check("nowd_timeout", {31'd0, timeout}, 32'd0);
            @(negedge clk);
        end
        doneFP = 1'b1;
        resBus = 32'h3F800000;
        @(negedge clk);
        doneFP = 1'b0;
        exp_result = 32'h3F800000;
        check("nowd_result", result, exp_result);
        check("nowd_resValid", {31'd0, resValid}, 32'd1);
        @(negedge clk);
        check("nowd_idle", {31'd0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
